overlay_stream_fetch: RTL and testbench
=======================================

Name: overlay_stream_fetch

Overview:
- Parametrised overlay pixel streamer that replaces the fixed two-pixel fetch register on the overlay path.
- Prefetches packed overlay words from the SDRAM read channel into a word FIFO.
- Unpacks them into pixels, emitting one pixel per active `ce_pix`, and restarts at `BASE_ADDR` on every vsync rising edge.
- Sits between the SDRAM channel and the alpha-blend/colour mixer in the video clock domain.

Parameters:
- PIX_W, 16: pixel width in bits (RGBA4444 default).
- WORD_W, 32: memory word width; must be an integer multiple of PIX_W. PPW = WORD_W/PIX_W.
- FIFO_DEPTH, 8: word FIFO entries; power of two, ≥2.
- ADDR_W, 24: word-address width.
- BASE_ADDR, 0: word address of the first overlay word of each frame.

Ports:
- clock  in  1  video/fetch clock
- reset  in  1  synchronous, active-high
- enable  in  1  overlay in use. When 0: FIFO flushed, no requests issued, pix_out forced 0.
- ce_pix  in  1  pixel clock enable
- hblank  in  1  horizontal blank
- vblank  in  1  vertical blank
- vsync  in  1  frame sync; rising edge restarts the stream
- mem_req  out  1  read request; held until mem_ack
- mem_addr  out  ADDR_W  word address; stable while mem_req=1
- mem_ack  in  1  request accepted (single-cycle)
- mem_rvalid  in  1  read data valid (single-cycle, arrives after mem_ack)
- mem_rdata  in  WORD_W  read data
- pix_out  out  PIX_W  current overlay pixel
- pix_valid  out  1  pix_out holds fetched data
- underrun  out  1  sticky per frame: an active pixel found no data

Behaviour:
- Reset values: mem_req=0, mem_addr=BASE_ADDR, pix_out=0, pix_valid=0, underrun=0, FIFO empty, sub-pixel index=0, state=IDLE, discard=0.
- vsync edge: vsync is registered every clock. A rise (old=0, new=1) is a restart event, with no ce_pix qualification.
- Fetch FSM has three states:
  - IDLE: when enable=1, no restart this cycle, and (FIFO count + 0 pending) < FIFO_DEPTH, assert mem_req with the current address and go to ISSUE.
  - ISSUE: hold mem_req and mem_addr. On mem_ack: drop mem_req, increment the address (wraps mod 2^ADDR_W), go to WAIT.
  - WAIT: on mem_rvalid, write mem_rdata to the FIFO unless discard=1 (then drop it and clear discard). Return to IDLE.
  - One request outstanding at most; the FIFO never overflows because a free slot is guaranteed at issue.
- Restart event:
  - FIFO flushed, sub-index=0, address=BASE_ADDR, underrun cleared.
  - If state is ISSUE or WAIT, set discard=1. The in-flight request completes per handshake and its data is dropped.
  - If the restart coincides with mem_rvalid, that data is dropped and discard is not set.
  - Restart takes priority over pixel pops in the same cycle.
- Pixel path: all updates happen on cycles with ce_pix=1.
  - Active (~hblank & ~vblank & enable), FIFO non-empty: pix_out <= head word bits [idx*PIX_W +: PIX_W], least-significant pixel first; pix_valid<=1; idx++. When idx==PPW-1, pop the head and set idx=0.
  - Active, FIFO empty: pix_out<=0, pix_valid<=0, underrun<=1.
  - Not active: pix_out<=0, pix_valid<=0, idx unchanged.
- Latency: pix_out updates on the clock edge where ce_pix is sampled high (1-clock registered). The first active pixel of a frame is valid if the first word has landed.
- A FIFO write and pop in the same cycle are both performed and the count is unchanged.
- enable=0: behaves as a continuous restart, except underrun holds its value.
- A request already in ISSUE/WAIT completes and is discarded.

Optional Feature:
- Macro: OVERLAY_FETCH_STATS_EN.
- When defined, adds output underrun_count [15:0]:
  - Counts underrun pixels in the current frame, saturating at 16'hFFFF.
  - On the restart event the running count is copied to underrun_count and the running count is cleared.
  - underrun_count resets to 0.
- When undefined, the port and counters are absent; only the sticky underrun flag exists.

Test Plan:
- Reset, enable=1, memory acks in 1 clock and returns data 3 clocks later with word N = {16'h(2N+1),16'h(2N)} -> first mem_addr=0; addresses then 1,2,…; active pixels read 0000,0001,0002,… in order with pix_valid=1 and underrun=0.
- Memory stalls ack for 200 clocks while 20 active ce_pix pulses occur -> pix_out=0, pix_valid=0 on those pixels; underrun=1 until the next vsync rise, then cleared.
- FIFO_DEPTH=4, blanking held for 50 clocks -> exactly 4 requests issued, then mem_req stays 0 until a pixel pop frees a slot.
- vsync rise while in WAIT for address 5 -> the returned word is discarded; the next request uses address BASE_ADDR; the first active pixel equals the low half of word BASE_ADDR.
- vsync rise in the same cycle as mem_rvalid -> that data is not written; the FIFO is empty next cycle; discard=0.
- With OVERLAY_FETCH_STATS_EN, 7 underrun pixels in frame 1 -> underrun_count=7 after the vsync rise, and 0 after the next clean frame.

Source files
------------

// File: rtl/overlay_stream_fetch_if.sv
// SDRAM read-channel handshake used by the overlay pixel streamer.
// The master issues word reads and the slave returns one data beat per accepted request.
interface overlay_stream_fetch_if #(
    parameter int ADDR_W = 24,
    parameter int WORD_W = 32
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/overlay_stream_fetch.sv
// Overlay pixel streamer: prefetches packed words into a FIFO and unpacks one pixel per ce_pix.
// Optional per-frame underrun counter output is enabled by defining OVERLAY_FETCH_STATS_EN.
module overlay_stream_fetch #(
    parameter int                PIX_W      = 16,
    parameter int                WORD_W     = 32,
    parameter int                FIFO_DEPTH = 8,
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   ce_pix,
    input  logic                   hblank,
    input  logic                   vblank,
    input  logic                   vsync,
    overlay_stream_fetch_if.master mem,
    output logic [PIX_W-1:0]       pix_out,
    output logic                   pix_valid,
    output logic                   underrun
`ifdef OVERLAY_FETCH_STATS_EN
    ,
    output logic [15:0]            underrun_count
`endif
);
    localparam int PPW   = WORD_W / PIX_W;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    logic              vsync_q;
    logic              discard;
    logic [ADDR_W-1:0] fetch_addr;

    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [IDX_W-1:0]  idx;

    logic vs_rise, flush, active, fifo_empty, fifo_wr, fifo_pop, under_pix;

    // enable=0 flushes like a restart every cycle; only a real vsync rise clears underrun.
    assign vs_rise    = vsync & ~vsync_q;
    assign flush      = vs_rise | ~enable;
    assign active     = ~hblank & ~vblank & enable;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_wr    = (state == WAIT) && mem.mem_rvalid && !discard && !flush;
    assign fifo_pop   = ce_pix && active && !fifo_empty && (idx == IDX_W'(PPW - 1)) && !flush;
    assign under_pix  = ce_pix && active && fifo_empty && !flush;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= BASE_ADDR;
            fetch_addr   <= BASE_ADDR;
            discard      <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (flush)
                fetch_addr <= BASE_ADDR;
            case (state)
                IDLE: begin
                    // mem_addr is loaded only at issue so it stays stable while mem_req is held.
                    if (enable && !flush && (fifo_cnt < CNT_W'(FIFO_DEPTH))) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= fetch_addr;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush)
                        discard <= 1'b1;
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        // A request doomed to be discarded must not advance the new frame's address.
                        if (!flush && !discard)
                            fetch_addr <= fetch_addr + 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        discard <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: FIFO storage carries no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= mem.mem_rdata;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            idx       <= '0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                idx      <= '0;
            end else begin
                if (fifo_wr)
                    wr_ptr <= wr_ptr + 1'b1;
                if (fifo_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({fifo_wr, fifo_pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
                if (ce_pix && active && !fifo_empty)
                    idx <= fifo_pop ? '0 : idx + 1'b1;
            end

            if (vs_rise)
                underrun <= 1'b0;
            else if (under_pix)
                underrun <= 1'b1;

            if (flush) begin
                if (ce_pix || !enable) begin
                    pix_out   <= '0;
                    pix_valid <= 1'b0;
                end
            end else if (ce_pix) begin
                if (active && !fifo_empty) begin
                    pix_out   <= fifo_mem[rd_ptr][int'(idx) * PIX_W +: PIX_W];
                    pix_valid <= 1'b1;
                end else begin
                    pix_out   <= '0;
                    pix_valid <= 1'b0;
                end
            end
        end
    end

`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0] run_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            run_cnt        <= '0;
            underrun_count <= '0;
        end else if (vs_rise) begin
            underrun_count <= run_cnt;
            run_cnt        <= '0;
        end else if (under_pix && (run_cnt != 16'hFFFF)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_overlay_stream_fetch.sv
// Directed bench for overlay_stream_fetch with a fixed-latency memory model (ack 1 clock, data 3 later).
// Word N returns {2N+1, 2N}, so the pixel stream of a frame reads 0,1,2,... from BASE_ADDR=0.
module tb_overlay_stream_fetch;
    localparam int PIX_W      = 16;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 24;
    localparam int FIFO_DEPTH = 4;

    logic             clk_sys = 1'b0;
    logic             reset   = 1'b1;
    logic             enable  = 1'b1;
    logic             ce_pix  = 1'b0;
    logic             hblank  = 1'b1;
    logic             vblank  = 1'b0;
    logic             vsync   = 1'b0;
    logic [PIX_W-1:0] pix_out;
    logic             pix_valid;
    logic             underrun;
`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0]      underrun_count;
`endif

    overlay_stream_fetch_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) mem_bus ();

    overlay_stream_fetch #(
        .PIX_W(PIX_W), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .enable(enable),
        .ce_pix(ce_pix),
        .hblank(hblank),
        .vblank(vblank),
        .vsync(vsync),
        .mem(mem_bus),
        .pix_out(pix_out),
        .pix_valid(pix_valid),
        .underrun(underrun)
`ifdef OVERLAY_FETCH_STATS_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    bit                stall    = 1'b0;
    int                rv_cnt   = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    int                ack_cnt  = 0;
    logic [ADDR_W-1:0] ack_log[$];

    // Memory slave: drives on the falling edge, so the DUT samples settled values.
    initial begin
        mem_bus.mem_ack    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
        forever begin
            @(negedge clk_sys);
            mem_bus.mem_ack    = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata  = {16'(2 * int'(pend_addr) + 1), 16'(2 * int'(pend_addr))};
                end
            end
            if (mem_bus.mem_req && !stall) begin
                mem_bus.mem_ack = 1'b1;
                pend_addr       = mem_bus.mem_addr;
                rv_cnt          = 3;
                ack_log.push_back(mem_bus.mem_addr);
                ack_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pixel(input bit act);
        ce_pix = 1'b1;
        hblank = !act;
        tick();
        ce_pix = 1'b0;
        hblank = 1'b1;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic expect_pixels(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            pixel(1'b1);
            check({tag, "_pix"}, 32'(pix_out), i);
            check({tag, "_valid"}, 32'(pix_valid), 1);
        end
    endtask

    int  n_before;
    bit  found;

    initial begin
        // Reset state
        ticks(3);
        check("rst_mem_req", 32'(mem_bus.mem_req), 0);
        check("rst_mem_addr", 32'(mem_bus.mem_addr), 0);
        check("rst_pix_out", 32'(pix_out), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_underrun", 32'(underrun), 0);
        reset = 1'b0;

        // Blanking: prefetch stops once all FIFO slots are claimed
        ticks(50);
        check("fill_ack_count", ack_cnt, FIFO_DEPTH);
        check("fill_req_idle", 32'(mem_bus.mem_req), 0);
        check("first_addr", 32'(ack_log[0]), 0);
        check("fourth_addr", 32'(ack_log[3]), 3);

        // Active pixels in order, least-significant pixel first
        expect_pixels("stream", 8);
        check("stream_underrun", 32'(underrun), 0);
        ticks(10);
        check("pop_frees_slot", 32'(ack_cnt > FIFO_DEPTH), 1);

        // Memory stall: active pixels find no data
        stall = 1'b1;
        ticks(10);
        vsync_pulse();
        for (int i = 0; i < 20; i++) begin
            pixel(1'b1);
            check("stall_pix", 32'(pix_out), 0);
            check("stall_valid", 32'(pix_valid), 0);
            ticks(9);
        end
        check("stall_underrun", 32'(underrun), 1);
        enable = 1'b0;
        ticks(3);
        check("disable_holds_underrun", 32'(underrun), 1);
        enable = 1'b1;
        stall  = 1'b0;
        ticks(40);
        check("underrun_sticky", 32'(underrun), 1);
        vsync_pulse();
        check("underrun_cleared", 32'(underrun), 0);
        ticks(40);
        expect_pixels("restart", 4);

        // Restart while waiting for word 5: that word is dropped, fetch resumes at BASE_ADDR
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (rv_cnt > 0 && pend_addr == ADDR_W'(5)) found = 1'b1;
        end
        check("wait5_reached", 32'(found), 1);
        n_before = ack_cnt;
        vsync_pulse();
        ticks(40);
        check("post_restart_addr", 32'(ack_log[n_before]), 0);
        expect_pixels("discard", 8);

        // Disabling forces the pixel output low at once
        enable = 1'b0;
        tick();
        check("disable_pix_out", 32'(pix_out), 0);
        check("disable_pix_valid", 32'(pix_valid), 0);
        enable = 1'b1;

        // Restart in the same cycle as returning data
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (rv_cnt == 1) found = 1'b1;
        end
        check("rvalid_next_reached", 32'(found), 1);
        vsync_pulse();
        check("coincide_fifo_empty", 32'(dut.fifo_cnt), 0);
        check("coincide_discard", 32'(dut.discard), 0);
        ticks(40);
        expect_pixels("coincide", 2);

`ifdef OVERLAY_FETCH_STATS_EN
        // Frame with 7 underrun pixels, then a clean frame
        stall = 1'b1;
        ticks(10);
        vsync_pulse();
        for (int i = 0; i < 7; i++) begin
            pixel(1'b1);
            ticks(2);
        end
        vsync_pulse();
        check("stats_seven", 32'(underrun_count), 7);
        stall = 1'b0;
        ticks(40);
        expect_pixels("stats_clean", 2);
        vsync_pulse();
        check("stats_clean_zero", 32'(underrun_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
